hazard_ctrl: RTL and testbench

//   Parametrised pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).

---
 rtl/hazard_ctrl_pkg.sv | 32 +++
 rtl/hazard_perf_cnt.sv | 28 ++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// register-address defaults and the packed bundle of stall/flush enables.
package hazard_ctrl_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int X0_IDX     = 0;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_MEM_WAIT = 2'd2,
    HZ_MDU_WAIT = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic memwb_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NONE     = hz_ctrl_t'(7'b000_0000);
  localparam hz_ctrl_t CTRL_FREEZE   = hz_ctrl_t'(7'b110_1011);
  localparam hz_ctrl_t CTRL_LOAD_USE = hz_ctrl_t'(7'b110_0100);
  localparam hz_ctrl_t CTRL_REDIRECT = hz_ctrl_t'(7'b001_0100);
  // EX/MEM keeps advancing during an MDU stall and picks up the bubble from EX.
  localparam hz_ctrl_t CTRL_MDU      = hz_ctrl_t'(7'b110_1000);

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for the hazard performance counters.
// Only compiled when HAZARD_PERF_EN is defined.
`ifdef HAZARD_PERF_EN
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != {CNT_W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use stalls, redirect
// flushes and memory/MDU freezes. HAZARD_PERF_EN adds stall/flush perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int LOAD_DELAY = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic              ifid_rs1_used,
  input  logic              ifid_rs2_used,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              idex_mem_read,
  input  logic              ex_redirect,
  input  logic              mdu_busy,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_stall,
  output logic              idex_flush,
  output logic              exmem_stall,
  output logic              memwb_flush,
  output logic [1:0]        hz_state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  hz_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  hz_ctrl_t   ctrl;
  logic       mem_wait;
  logic       lu_hit;
  logic       in_lu_stall;

  assign mem_wait = dmem_req & ~dmem_ready;
  assign lu_hit   = idex_mem_read && (idex_rd != REG_AW'(X0_IDX)) &&
                    ((ifid_rs1_used && (ifid_rs1 == idex_rd)) ||
                     (ifid_rs2_used && (ifid_rs2 == idex_rd)));

  // A freeze that interrupted a load-use stall keeps cnt, so it resumes on release.
  assign in_lu_stall = (state_q == HZ_LU_STALL) ||
                       ((state_q == HZ_MEM_WAIT) && (cnt_q != 2'd0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = CTRL_NONE;
    if (mem_wait) begin
      ctrl    = CTRL_FREEZE;
      state_d = HZ_MEM_WAIT;
    end else if (in_lu_stall) begin
      if (ex_redirect) begin
        ctrl    = CTRL_REDIRECT;
        cnt_d   = 2'd0;
        state_d = HZ_RUN;
      end else begin
        ctrl    = CTRL_LOAD_USE;
        cnt_d   = cnt_q - 2'd1;
        state_d = (cnt_q == 2'd1) ? HZ_RUN : HZ_LU_STALL;
      end
    end else if (mdu_busy) begin
      ctrl    = CTRL_MDU;
      state_d = HZ_MDU_WAIT;
    end else if (ex_redirect) begin
      ctrl    = CTRL_REDIRECT;
      state_d = HZ_RUN;
    end else if (lu_hit) begin
      ctrl = CTRL_LOAD_USE;
      if (LOAD_DELAY > 1) begin
        cnt_d   = 2'(LOAD_DELAY - 1);
        state_d = HZ_LU_STALL;
      end else begin
        state_d = HZ_RUN;
      end
    end else begin
      state_d = HZ_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_stall    = ctrl.pc_stall;
  assign ifid_stall  = ctrl.ifid_stall;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_stall  = ctrl.idex_stall;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_stall = ctrl.exmem_stall;
  assign memwb_flush = ctrl.memwb_flush;
  assign hz_state    = state_q;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl.pc_stall),
    .count (stall_cnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl.ifid_flush),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (LOAD_DELAY=1 and 2) share the
// stimulus and are compared every cycle against a stall-budget reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       ifid_rs1_used, ifid_rs2_used, idex_mem_read;
  logic       ex_redirect, mdu_busy, dmem_req, dmem_ready;

  // Output bundles ordered {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush}
  wire [6:0]  out_a, out_b;
  wire [1:0]  hz_state_a, hz_state_b;
  wire [31:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;

  int vectors = 0;
  int fails   = 0;

  // Reference model: remaining load-use bubbles and expected FSM state per instance
  int          pend_a = 0, pend_b = 0, npend_a, npend_b;
  logic [1:0]  st_a = 2'd0, st_b = 2'd0, nst_a, nst_b;
  logic [6:0]  exp_a, exp_b;
  logic [31:0] sc_a = 0, fc_a = 0, sc_b = 0, fc_b = 0;
  logic [31:0] want_sc_a, want_fc_a, want_sc_b, want_fc_b;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .LOAD_DELAY(1), .CNT_W(32)) u_dut_a (
    .clk(clk), .rst(rst),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_rs1_used(ifid_rs1_used), .ifid_rs2_used(ifid_rs2_used),
    .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
    .ex_redirect(ex_redirect), .mdu_busy(mdu_busy),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(out_a[6]), .ifid_stall(out_a[5]), .ifid_flush(out_a[4]),
    .idex_stall(out_a[3]), .idex_flush(out_a[2]), .exmem_stall(out_a[1]),
    .memwb_flush(out_a[0]), .hz_state(hz_state_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  hazard_ctrl #(.REG_AW(5), .LOAD_DELAY(2), .CNT_W(32)) u_dut_b (
    .clk(clk), .rst(rst),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_rs1_used(ifid_rs1_used), .ifid_rs2_used(ifid_rs2_used),
    .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
    .ex_redirect(ex_redirect), .mdu_busy(mdu_busy),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(out_b[6]), .ifid_stall(out_b[5]), .ifid_flush(out_b[4]),
    .idex_stall(out_b[3]), .idex_flush(out_b[2]), .exmem_stall(out_b[1]),
    .memwb_flush(out_b[0]), .hz_state(hz_state_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  // Behavioural rules: freeze beats everything, a pending load-use budget is spent
  // (or cancelled by a redirect), then MDU, redirect, and finally a new load-use hit.
  task automatic model_eval(input int ld, input int pend,
                            output logic [6:0] o, output logic [1:0] nst, output int npend);
    bit hit;
    hit = idex_mem_read && (idex_rd != 0) &&
          ((ifid_rs1_used && ifid_rs1 == idex_rd) || (ifid_rs2_used && ifid_rs2 == idex_rd));
    npend = pend;
    if (dmem_req && !dmem_ready) begin
      o = 7'b1101011; nst = 2'd2;
    end else if (pend > 0) begin
      if (ex_redirect) begin
        o = 7'b0010100; npend = 0;
      end else begin
        o = 7'b1100100; npend = pend - 1;
      end
      nst = (npend > 0) ? 2'd1 : 2'd0;
    end else if (mdu_busy) begin
      o = 7'b1101000; nst = 2'd3;
    end else if (ex_redirect) begin
      o = 7'b0010100; nst = 2'd0;
    end else if (hit) begin
      o = 7'b1100100; npend = ld - 1; nst = (npend > 0) ? 2'd1 : 2'd0;
    end else begin
      o = 7'b0000000; nst = 2'd0;
    end
  endtask

  task automatic settle();
    #4;
    model_eval(1, pend_a, exp_a, nst_a, npend_a);
    model_eval(2, pend_b, exp_b, nst_b, npend_b);
  endtask

  task automatic tick();
    if (rst) begin
      pend_a = 0; pend_b = 0; st_a = 2'd0; st_b = 2'd0;
      sc_a = 0; fc_a = 0; sc_b = 0; fc_b = 0;
    end else begin
      pend_a = npend_a; pend_b = npend_b; st_a = nst_a; st_b = nst_b;
      if (exp_a[6] && sc_a != '1) sc_a++;
      if (exp_a[4] && fc_a != '1) fc_a++;
      if (exp_b[6] && sc_b != '1) sc_b++;
      if (exp_b[4] && fc_b != '1) fc_b++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ifid_rs1 = 0; ifid_rs2 = 0; ifid_rs1_used = 0; ifid_rs2_used = 0;
    idex_rd = 0; idex_mem_read = 0; ex_redirect = 0; mdu_busy = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic load_counter_expect();
`ifdef HAZARD_PERF_EN
    want_sc_a = sc_a; want_fc_a = fc_a; want_sc_b = sc_b; want_fc_b = fc_b;
`else
    want_sc_a = 0; want_fc_a = 0; want_sc_b = 0; want_fc_b = 0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    tick();
    tick();
    rst = 1'b0;
    settle();
    vectors++;
    if ({out_a, hz_state_a, out_b, hz_state_b} !== {7'b0, 2'd0, 7'b0, 2'd0}) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got a=%b/%0d b=%b/%0d want all 0", out_a, hz_state_a, out_b, hz_state_b);
    end
    vectors++;
    if ({stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b} !== 128'd0) begin
      fails++;
      $display("[TB] FAIL reset_counters: got %0d %0d %0d %0d want 0", stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b);
    end
    tick();
  endtask

  task automatic test_load_use();
    // lw x5 in EX, add x6,x5,x1 in ID
    set_idle();
    idex_mem_read = 1; idex_rd = 5; ifid_rs1 = 5; ifid_rs1_used = 1; ifid_rs2 = 1; ifid_rs2_used = 1;
    settle();
    vectors++;
    if (out_a !== 7'b1100100 || out_a !== exp_a) begin
      fails++;
      $display("[TB] FAIL load_use_stall: got %b want %b", out_a, exp_a);
    end
    tick();
    set_idle();
    ifid_rs1 = 5; ifid_rs1_used = 1; ifid_rs2 = 1; ifid_rs2_used = 1;
    settle();
    vectors++;
    if ({out_a, hz_state_a} !== {exp_a, st_a}) begin
      fails++;
      $display("[TB] FAIL load_use_release: got %b/%0d want %b/%0d", out_a, hz_state_a, exp_a, st_a);
    end
    tick();
    set_idle();
    settle();
    tick();
  endtask

  task automatic test_x0_unused();
    set_idle();
    idex_mem_read = 1; idex_rd = 0; ifid_rs1_used = 1; ifid_rs2_used = 1;
    settle();
    vectors++;
    if ({out_a, out_b} !== {exp_a, exp_b} || out_b !== 7'b0) begin
      fails++;
      $display("[TB] FAIL x0_filter: got a=%b b=%b want a=%b b=%b", out_a, out_b, exp_a, exp_b);
    end
    tick();
    set_idle();
    idex_mem_read = 1; idex_rd = 5; ifid_rs1 = 5; ifid_rs2 = 5;
    settle();
    vectors++;
    if ({out_a, out_b} !== {exp_a, exp_b} || out_b !== 7'b0) begin
      fails++;
      $display("[TB] FAIL unused_filter: got a=%b b=%b want a=%b b=%b", out_a, out_b, exp_a, exp_b);
    end
    tick();
  endtask

  task automatic test_load_delay2();
    set_idle();
    idex_mem_read = 1; idex_rd = 7; ifid_rs1 = 2; ifid_rs1_used = 1; ifid_rs2 = 7; ifid_rs2_used = 1;
    for (int c = 0; c < 3; c++) begin
      settle();
      vectors++;
      if ({out_b, hz_state_b} !== {exp_b, st_b}) begin
        fails++;
        $display("[TB] FAIL ld2_cycle%0d: got %b/%0d want %b/%0d", c, out_b, hz_state_b, exp_b, st_b);
      end
      tick();
      set_idle();
      ifid_rs1 = 2; ifid_rs1_used = 1; ifid_rs2 = 7; ifid_rs2_used = 1;
    end
  endtask

  task automatic test_redirect_beats_lu();
    set_idle();
    idex_mem_read = 1; idex_rd = 3; ifid_rs1 = 3; ifid_rs1_used = 1; ex_redirect = 1;
    settle();
    vectors++;
    if ({out_a, out_b} !== {exp_a, exp_b} || out_a !== 7'b0010100) begin
      fails++;
      $display("[TB] FAIL redirect_vs_lu: got a=%b b=%b want a=%b b=%b", out_a, out_b, exp_a, exp_b);
    end
    tick();
    set_idle();
    settle();
    vectors++;
    if ({out_b, hz_state_b} !== {exp_b, st_b}) begin
      fails++;
      $display("[TB] FAIL redirect_one_cycle: got %b/%0d want %b/%0d", out_b, hz_state_b, exp_b, st_b);
    end
    tick();
  endtask

  task automatic test_freeze_redirect();
    set_idle();
    ex_redirect = 1; dmem_req = 1; dmem_ready = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) dmem_ready = 1;
      settle();
      vectors++;
      if ({out_a, hz_state_a} !== {exp_a, st_a}) begin
        fails++;
        $display("[TB] FAIL freeze_cycle%0d: got %b/%0d want %b/%0d", c, out_a, hz_state_a, exp_a, st_a);
      end
      tick();
    end
    set_idle();
    settle();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    set_idle();
    idex_mem_read = 1; idex_rd = 9; ifid_rs2 = 9; ifid_rs2_used = 1;
    settle();
    tick();
    set_idle();
    settle();
    vectors++;
    if (hz_state_b !== 2'd1 || hz_state_b !== st_b) begin
      fails++;
      $display("[TB] FAIL enter_lu_stall: got st=%0d want %0d", hz_state_b, st_b);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    vectors++;
    if ({out_b, hz_state_b, stall_cnt_b, flush_cnt_b} !== {7'b0, 2'd0, 64'd0}) begin
      fails++;
      $display("[TB] FAIL reset_mid_stall: got %b/%0d cnt=%0d/%0d want 0", out_b, hz_state_b, stall_cnt_b, flush_cnt_b);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      rst           = ($urandom_range(0, 59) == 0);
      ifid_rs1      = 5'($urandom_range(0, 3));
      ifid_rs2      = 5'($urandom_range(0, 3));
      idex_rd       = 5'($urandom_range(0, 3));
      ifid_rs1_used = ($urandom_range(0, 3) != 0);
      ifid_rs2_used = ($urandom_range(0, 3) != 0);
      idex_mem_read = ($urandom_range(0, 1) == 1);
      ex_redirect   = ($urandom_range(0, 5) == 0);
      mdu_busy      = ($urandom_range(0, 7) == 0);
      dmem_req      = ($urandom_range(0, 2) == 0);
      dmem_ready    = ($urandom_range(0, 1) == 1);
      settle();
      if (!rst) begin
        vectors++;
        if ({out_a, hz_state_a, out_b, hz_state_b} !== {exp_a, st_a, exp_b, st_b}) begin
          fails++;
          $display("[TB] FAIL random_%0d: got a=%b/%0d b=%b/%0d want a=%b/%0d b=%b/%0d",
                   n, out_a, hz_state_a, out_b, hz_state_b, exp_a, st_a, exp_b, st_b);
        end
      end
      tick();
    end
    rst = 1'b0;
    set_idle();
    settle();
    load_counter_expect();
    vectors++;
    if ({stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b} !== {want_sc_a, want_fc_a, want_sc_b, want_fc_b}) begin
      fails++;
      $display("[TB] FAIL perf_counters: got %0d %0d %0d %0d want %0d %0d %0d %0d",
               stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b, want_sc_a, want_fc_a, want_sc_b, want_fc_b);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    #1;
    test_reset();
    test_load_use();
    test_x0_unused();
    test_load_delay2();
    test_redirect_beats_lu();
    test_freeze_redirect();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
